// File: rtl/bdi_cache_frontend_pkg.sv
// Shared types and helpers for the BDI cache front end: FSM state encoding,
// watchdog sizing and saturating counter arithmetic.
package bdi_frontend_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Watchdog counts 0..TIMEOUT-1 inside ISSUE, so this many bits are enough.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return $clog2(timeout);
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/bdi_cache_frontend_if.sv
// Requester, response, downstream and statistics signals of the front end.
// The front end takes the slave modport; requesters/downstream take master.
interface bdi_cache_frontend_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) ();

  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        req_op_rd;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;

  logic [NUM_PORTS-1:0]        resp_valid;
  logic [DATA_W-1:0]           resp_rdata;
  logic                        resp_hit;
  logic                        resp_err;

  logic                        ds_req;
  logic                        ds_op_rd;
  logic [ADDR_W-1:0]           ds_address;
  logic [DATA_W-1:0]           ds_wdata;
  logic                        ds_ack;
  logic [DATA_W-1:0]           ds_rdata;
  logic                        ds_hit;

  logic                        stat_clear;
  logic [CNT_W-1:0]            stat_rd_hit;
  logic [CNT_W-1:0]            stat_rd_miss;
  logic [CNT_W-1:0]            stat_wr;
  logic [CNT_W-1:0]            stat_timeout;

  modport slave (
    input  req_valid, req_op_rd, req_addr, req_wdata,
    input  ds_ack, ds_rdata, ds_hit, stat_clear,
    output req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
    output ds_req, ds_op_rd, ds_address, ds_wdata,
    output stat_rd_hit, stat_rd_miss, stat_wr, stat_timeout
  );

  modport master (
    output req_valid, req_op_rd, req_addr, req_wdata,
    output ds_ack, ds_rdata, ds_hit, stat_clear,
    input  req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
    input  ds_req, ds_op_rd, ds_address, ds_wdata,
    input  stat_rd_hit, stat_rd_miss, stat_wr, stat_timeout
  );

endinterface

// File: rtl/bdi_cache_frontend_arb.sv
// Combinational round-robin arbiter: grants the first requesting port at or
// after i_ptr, wrapping. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_ptr,
  input  logic                 i_en,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [IDX_W-1:0]     o_grant_idx
);

  logic [IDX_W:0] w_sum;
  logic           w_found;

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_sum       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(NUM_PORTS)) w_sum = w_sum - (IDX_W+1)'(NUM_PORTS);
      if (i_en && !w_found && i_req[w_sum[IDX_W-1:0]]) begin
        w_found                     = 1'b1;
        o_grant[w_sum[IDX_W-1:0]]   = 1'b1;
        o_grant_idx                 = w_sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bdi_cache_frontend.sv
// Multi-requester front end: round-robin accept, single outstanding
// downstream request with watchdog abort, one-cycle response, statistics.
module bdi_cache_frontend
  import bdi_frontend_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  bdi_cache_frontend_if.slave   bus
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WD_W  = wd_width(TIMEOUT);

  state_e                r_state, w_next_state;
  logic [IDX_W-1:0]      r_ptr, w_grant_idx;
  logic [NUM_PORTS-1:0]  w_grant, r_grant_oh;
  logic                  w_arb_en;
  logic                  w_sel_op_rd, r_op_rd;
  logic [ADDR_W-1:0]     w_sel_addr, r_addr;
  logic [DATA_W-1:0]     w_sel_wdata, r_wdata, r_rdata;
  logic                  r_hit, r_err;
  logic [WD_W-1:0]       r_wd;
  logic                  w_timeout;
  logic [CNT_W-1:0]      r_stat_rd_hit, r_stat_rd_miss, r_stat_wr, r_stat_timeout;

  assign w_arb_en  = (r_state == IDLE);
  assign w_timeout = (r_wd == WD_W'(TIMEOUT - 1));

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_arb (
    .i_req       (bus.req_valid),
    .i_ptr       (r_ptr),
    .i_en        (w_arb_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // One-hot payload mux driven by the grant vector.
  always_comb begin
    w_sel_op_rd = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_grant[p]) begin
        w_sel_op_rd = bus.req_op_rd[p];
        w_sel_addr  = bus.req_addr[p*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.req_wdata[p*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.resp_rdata = '0;
    bus.resp_hit   = 1'b0;
    bus.resp_err   = 1'b0;
    bus.ds_req     = 1'b0;
    bus.ds_op_rd   = 1'b0;
    bus.ds_address = '0;
    bus.ds_wdata   = '0;
    unique case (r_state)
      IDLE: begin
        bus.req_ready = w_grant;
        if (|w_grant) w_next_state = ISSUE;
      end
      ISSUE: begin
        bus.ds_req     = 1'b1;
        bus.ds_op_rd   = r_op_rd;
        bus.ds_address = r_addr;
        bus.ds_wdata   = r_wdata;
        if (bus.ds_ack || w_timeout) w_next_state = RESP;
      end
      RESP: begin
        bus.resp_valid = r_grant_oh;
        bus.resp_rdata = r_rdata;
        bus.resp_hit   = r_hit;
        bus.resp_err   = r_err;
        w_next_state   = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr      <= '0;
      r_grant_oh <= '0;
      r_op_rd    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_hit      <= 1'b0;
      r_err      <= 1'b0;
      r_wd       <= '0;
    end else begin
      case (r_state)
        IDLE: if (|w_grant) begin
          r_grant_oh <= w_grant;
          r_op_rd    <= w_sel_op_rd;
          r_addr     <= w_sel_addr;
          r_wdata    <= w_sel_wdata;
          r_ptr      <= (w_grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;
          r_rdata    <= '0;
          r_hit      <= 1'b0;
          r_err      <= 1'b0;
        end
        // Ack beats a coinciding watchdog expiry.
        ISSUE: if (bus.ds_ack) begin
          r_rdata <= r_op_rd ? bus.ds_rdata : '0;
          r_hit   <= r_op_rd & bus.ds_hit;
          r_err   <= 1'b0;
        end else if (w_timeout) begin
          r_rdata <= '0;
          r_hit   <= 1'b0;
          r_err   <= 1'b1;
        end
        default: ;
      endcase
      r_wd <= (r_state == ISSUE && w_next_state == ISSUE) ? r_wd + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || bus.stat_clear) begin
      r_stat_rd_hit  <= '0;
      r_stat_rd_miss <= '0;
      r_stat_wr      <= '0;
      r_stat_timeout <= '0;
    end else if (r_state == RESP) begin
      if (r_err)      r_stat_timeout <= CNT_W'(sat_inc(64'(r_stat_timeout), CNT_W));
      else if (!r_op_rd) r_stat_wr   <= CNT_W'(sat_inc(64'(r_stat_wr), CNT_W));
      else if (r_hit) r_stat_rd_hit  <= CNT_W'(sat_inc(64'(r_stat_rd_hit), CNT_W));
      else            r_stat_rd_miss <= CNT_W'(sat_inc(64'(r_stat_rd_miss), CNT_W));
    end
  end

  assign bus.stat_rd_hit  = r_stat_rd_hit;
  assign bus.stat_rd_miss = r_stat_rd_miss;
  assign bus.stat_wr      = r_stat_wr;
  assign bus.stat_timeout = r_stat_timeout;

endmodule

// File: tb/tb_bdi_cache_frontend.sv
// Directed bench for bdi_cache_frontend: 4 ports, 4-bit counters, TIMEOUT=16.
module tb_bdi_cache_frontend;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  bdi_cache_frontend_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .CNT_W(4)) bus ();

  bdi_cache_frontend #(
    .NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .CNT_W(4), .TIMEOUT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one request on a single port; ack_at is the 1-based ISSUE cycle carrying
  // ds_ack (0 = never). Entered and left just after a rising edge.
  task automatic txn(input int port, input logic rd, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input logic hit,
                     input int ack_at, input logic clr_resp,
                     output logic [3:0] o_ready, output logic [3:0] o_rv,
                     output logic [31:0] o_rd, output logic o_hit, output logic o_err,
                     output int n_issue, output int n_unstable);
    bus.req_valid = 4'b0001 << port;
    bus.req_op_rd = rd ? (4'b0001 << port) : 4'b0000;
    bus.req_addr  = 128'(addr) << (port * 32);
    bus.req_wdata = 128'(wdata) << (port * 32);
    #1;
    o_ready = bus.req_ready;
    tick();
    bus.req_valid = '0;
    n_issue = 0; n_unstable = 0;
    o_rv = '0; o_rd = '0; o_hit = 1'b0; o_err = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.resp_valid != 4'b0000) begin
        o_rv = bus.resp_valid; o_rd = bus.resp_rdata;
        o_hit = bus.resp_hit; o_err = bus.resp_err;
        break;
      end
      if (bus.ds_req) begin
        n_issue++;
        if (bus.ds_op_rd !== rd || bus.ds_address !== addr || (!rd && bus.ds_wdata !== wdata))
          n_unstable++;
      end
      bus.ds_rdata = rdata;
      bus.ds_hit   = hit;
      bus.ds_ack   = bus.ds_req && (n_issue == ack_at);
      tick();
    end
    bus.ds_ack     = 1'b0;
    bus.stat_clear = clr_resp;
    tick();
    bus.stat_clear = 1'b0;
  endtask

  logic [3:0]  r_ready, r_rv;
  logic [31:0] r_rd;
  logic        r_hit, r_err;
  int          n_iss, n_unst;
  int          exp_port [5] = '{0, 1, 2, 3, 0};

  initial begin
    n_cmp = 0; n_mis = 0;
    rst = 1'b0;
    bus.req_valid = '0; bus.req_op_rd = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.ds_ack = 1'b0; bus.ds_rdata = '0; bus.ds_hit = 1'b0; bus.stat_clear = 1'b0;
    tick(); tick();
    check("rst_ds_req", 32'(bus.ds_req), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_ds_address", bus.ds_address, 32'd0);
    check("rst_stat_rd_hit", 32'(bus.stat_rd_hit), 32'd0);
    rst = 1'b1;
    tick();

    // Round robin with all four ports requesting continuously.
    bus.req_valid = 4'b1111;
    bus.req_op_rd = 4'b1111;
    bus.req_addr  = {32'h1000_000C, 32'h1000_0008, 32'h1000_0004, 32'h1000_0000};
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_ready", 32'(bus.req_ready), 32'(4'b0001 << exp_port[k]));
      tick();
      bus.ds_ack = 1'b1; bus.ds_rdata = 32'hA0 + 32'(k); bus.ds_hit = 1'b0;
      #1;
      check("rr_ds_address", bus.ds_address, 32'h1000_0000 + 32'(4 * exp_port[k]));
      tick();
      bus.ds_ack = 1'b0;
      #1;
      check("rr_resp_valid", 32'(bus.resp_valid), 32'(4'b0001 << exp_port[k]));
      check("rr_resp_rdata", bus.resp_rdata, 32'hA0 + 32'(k));
      check("rr_ready_in_resp", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.req_valid = '0;
    check("rr_stat_rd_miss", 32'(bus.stat_rd_miss), 32'd5);

    // Single read hit on port 0, ack in the second ISSUE cycle.
    txn(0, 1'b1, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b1, 2, 1'b0,
        r_ready, r_rv, r_rd, r_hit, r_err, n_iss, n_unst);
    check("rd_ready", 32'(r_ready), 32'b0001);
    check("rd_resp_valid", 32'(r_rv), 32'b0001);
    check("rd_resp_rdata", r_rd, 32'hDEAD_BEEF);
    check("rd_resp_hit", 32'(r_hit), 32'd1);
    check("rd_issue_cycles", 32'(n_iss), 32'd2);
    check("rd_stat_rd_hit", 32'(bus.stat_rd_hit), 32'd1);

    // Write from port 2; payload must stay put across three ISSUE cycles.
    txn(2, 1'b0, 32'h0000_2000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 3, 1'b0,
        r_ready, r_rv, r_rd, r_hit, r_err, n_iss, n_unst);
    check("wr_resp_valid", 32'(r_rv), 32'b0100);
    check("wr_unstable_cycles", 32'(n_unst), 32'd0);
    check("wr_issue_cycles", 32'(n_iss), 32'd3);
    check("wr_resp_rdata", r_rd, 32'd0);
    check("wr_resp_hit", 32'(r_hit), 32'd0);
    check("wr_resp_err", 32'(r_err), 32'd0);
    check("wr_stat_wr", 32'(bus.stat_wr), 32'd1);

    // No ack at all: watchdog aborts after 16 ISSUE cycles.
    txn(1, 1'b1, 32'h0000_3000, 32'h0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0,
        r_ready, r_rv, r_rd, r_hit, r_err, n_iss, n_unst);
    check("to_resp_valid", 32'(r_rv), 32'b0010);
    check("to_issue_cycles", 32'(n_iss), 32'd16);
    check("to_resp_err", 32'(r_err), 32'd1);
    check("to_resp_rdata", r_rd, 32'd0);
    check("to_resp_hit", 32'(r_hit), 32'd0);
    check("to_stat_timeout", 32'(bus.stat_timeout), 32'd1);
    check("to_idle_ds_req", 32'(bus.ds_req), 32'd0);

    txn(1, 1'b1, 32'h0000_3004, 32'h0, 32'h0BAD_F00D, 1'b1, 1, 1'b0,
        r_ready, r_rv, r_rd, r_hit, r_err, n_iss, n_unst);
    check("after_to_err", 32'(r_err), 32'd0);
    check("after_to_rdata", r_rd, 32'h0BAD_F00D);
    check("after_to_stat_rd_hit", 32'(bus.stat_rd_hit), 32'd2);

    // Ack lands exactly on the watchdog's final cycle: ack wins.
    txn(1, 1'b1, 32'h0000_3008, 32'h0, 32'h0000_55AA, 1'b0, 16, 1'b0,
        r_ready, r_rv, r_rd, r_hit, r_err, n_iss, n_unst);
    check("ack_at_to_err", 32'(r_err), 32'd0);
    check("ack_at_to_rdata", r_rd, 32'h0000_55AA);
    check("ack_at_to_issue", 32'(n_iss), 32'd16);
    check("ack_at_to_stat_timeout", 32'(bus.stat_timeout), 32'd1);
    check("ack_at_to_stat_rd_miss", 32'(bus.stat_rd_miss), 32'd6);

    bus.stat_clear = 1'b1;
    tick();
    bus.stat_clear = 1'b0;
    check("clr_rd_miss", 32'(bus.stat_rd_miss), 32'd0);
    check("clr_rd_hit", 32'(bus.stat_rd_hit), 32'd0);
    check("clr_wr", 32'(bus.stat_wr), 32'd0);
    check("clr_timeout", 32'(bus.stat_timeout), 32'd0);

    // Drive the 4-bit miss counter to saturation.
    for (int k = 0; k < 15; k++)
      txn(0, 1'b1, 32'h0000_4000, 32'h0, 32'h0, 1'b0, 1, 1'b0,
          r_ready, r_rv, r_rd, r_hit, r_err, n_iss, n_unst);
    check("sat_rd_miss_15", 32'(bus.stat_rd_miss), 32'hF);
    txn(0, 1'b1, 32'h0000_4000, 32'h0, 32'h0, 1'b0, 1, 1'b0,
        r_ready, r_rv, r_rd, r_hit, r_err, n_iss, n_unst);
    check("sat_rd_miss_16", 32'(bus.stat_rd_miss), 32'hF);

    // Clear coinciding with the RESP of a hit: clear wins.
    txn(0, 1'b1, 32'h0000_4004, 32'h0, 32'h1111_2222, 1'b1, 1, 1'b1,
        r_ready, r_rv, r_rd, r_hit, r_err, n_iss, n_unst);
    check("clr_resp_hit", 32'(r_hit), 32'd1);
    check("clr_resp_rd_hit", 32'(bus.stat_rd_hit), 32'd0);
    check("clr_resp_rd_miss", 32'(bus.stat_rd_miss), 32'd0);

    // Reset in the middle of an ISSUE.
    bus.req_valid = 4'b0001; bus.req_op_rd = 4'b0001; bus.req_addr = 128'h40;
    #1;
    check("mid_rst_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    #1;
    check("mid_rst_ds_req_before", 32'(bus.ds_req), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_ds_req", 32'(bus.ds_req), 32'd0);
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    tick();
    check("mid_rst_resp_valid_held", 32'(bus.resp_valid), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    // Pointer back at 0: port 0 beats port 3.
    bus.req_valid = 4'b1001;
    #1;
    check("post_rst_ptr", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;
    #1;
    check("post_rst_drop", 32'(bus.req_ready), 32'd0);
    tick();
    txn(3, 1'b1, 32'h0000_003C, 32'h0, 32'hC0FF_EE00, 1'b1, 1, 1'b0,
        r_ready, r_rv, r_rd, r_hit, r_err, n_iss, n_unst);
    check("post_rst_resp_valid_p3", 32'(r_rv), 32'b1000);
    check("post_rst_rdata_p3", r_rd, 32'hC0FF_EE00);
    check("post_rst_hit_p3", 32'(r_hit), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bdi_cache_frontend.md
Name: bdi_cache_frontend

Overview:
- Parametrised multi-requester front end that sits above the BDI compressed-cache system.
- Arbitrates NUM_PORTS requesters round-robin and holds the granted request stable downstream until completion.
- Returns a one-cycle response (read data, hit flag, timeout error) to the winning port.
- Keeps saturating hit/miss/write/timeout statistics; a watchdog aborts requests that never complete.

Parameters:
- NUM_PORTS, 4, number of requesters (1..8)
- ADDR_W, 32, request address width
- DATA_W, 32, data word width
- CNT_W, 16, statistics counter width
- TIMEOUT, 1024, max cycles waiting for ds_ack before abort (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port accept pulse (one-hot)
- req_op_rd  in  NUM_PORTS  1=read, 0=write
- req_addr  in  NUM_PORTS*ADDR_W  flattened addresses, port p at [p*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_PORTS*DATA_W  flattened write data
- resp_valid  out  NUM_PORTS  one-hot response pulse
- resp_rdata  out  DATA_W  read data, valid with resp_valid
- resp_hit  out  1  cache hit flag for the responded read
- resp_err  out  1  request aborted by watchdog
- ds_req  out  1  downstream request active
- ds_op_rd  out  1  downstream op
- ds_address  out  ADDR_W  downstream address
- ds_wdata  out  DATA_W  downstream write data
- ds_ack  in  1  downstream completion pulse
- ds_rdata  in  DATA_W  downstream read data, sampled on ds_ack
- ds_hit  in  1  downstream hit flag, sampled on ds_ack
- stat_clear  in  1  synchronous clear of all counters
- stat_rd_hit, stat_rd_miss, stat_wr, stat_timeout  out  CNT_W each  saturating counters

Behaviour:
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - round-robin pointer = 0
  - watchdog = 0
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid, grant the first valid port at or after the pointer, wrapping modulo NUM_PORTS.
  - Pulse req_ready[grant] for exactly that cycle.
  - Latch op, addr and wdata into holding registers.
  - Pointer <= grant+1 (wrap).
  - Go to ISSUE.
  - No valid requests: stay in IDLE, all outputs idle.
- ISSUE:
  - ds_req=1; ds_op_rd, ds_address and ds_wdata driven from the holding registers, stable for the whole state.
  - Watchdog increments every cycle.
  - On ds_ack: capture ds_rdata/ds_hit, go to RESP.
  - Watchdog reaching TIMEOUT-1 with no ds_ack: set err, rdata=0, hit=0, go to RESP.
  - ds_ack in the same cycle as timeout: ack wins, no error.
- RESP:
  - resp_valid[grant]=1 for one cycle; resp_rdata/resp_hit/resp_err driven from the captured values.
  - ds_req=0; watchdog cleared.
  - Return to IDLE.
  - For writes, resp_rdata=0 and resp_hit=0.
- Latency: minimum 3 cycles from the accept cycle to resp_valid (accept, one ISSUE cycle with ds_ack, RESP). Maximum throughput is one request per 3 cycles.
- ds_ack outside ISSUE is ignored.
- Requester rules:
  - A requester must hold req_valid and its payload until it sees req_ready.
  - Deasserting req_valid before accept is legal; the port simply loses the arbitration.
- Statistics, updated in the RESP cycle:
  - err: stat_timeout+1
  - else read: stat_rd_hit+1 if hit, otherwise stat_rd_miss+1
  - else write: stat_wr+1
  - Counters saturate at all-ones, no wrap.
- stat_clear:
  - Zeroes all counters next edge.
  - Has priority over an increment in the same cycle.
  - Does not affect the FSM.
- Asynchronous reset mid-request:
  - Return to IDLE, drop ds_req immediately, no response is ever issued.
  - Requesters must re-issue.
- NUM_PORTS=1: arbiter degenerates to always granting port 0; the pointer stays 0.

Decomposition:
- Package bdi_frontend_pkg holds:
  - state enum (IDLE, ISSUE, RESP)
  - watchdog width constant $clog2(TIMEOUT)
  - function for saturating increment
- Sub-module rr_arbiter:
  - parametrised by NUM_PORTS
  - inputs: request vector, pointer, enable
  - outputs: one-hot grant, grant index
  - combinational, with pointer update owned by the top FSM

Test Plan:
- Single read, port 0, addr 0x0000_0040: ds_ack after 2 ISSUE cycles with ds_rdata=0xDEADBEEF, ds_hit=1 -> resp_valid=0001, resp_rdata=0xDEADBEEF, resp_hit=1, stat_rd_hit=1.
- Ports 0..3 all valid continuously, ds_ack 1 cycle into every ISSUE -> grant order 0,1,2,3,0; one response every 3 cycles; no port accepted twice before all others are served.
- Write from port 2, wdata 0x1234_5678 -> ds_address/ds_wdata stable for the whole ISSUE state; resp_rdata=0, resp_err=0, stat_wr=1.
- No ds_ack, TIMEOUT=16 -> resp_err=1 after 16 ISSUE cycles, stat_timeout=1, FSM back to IDLE; the next request is served normally.
- Force stat_rd_miss to all-ones (CNT_W=4, 15 misses), then one more miss -> counter stays 0xF. stat_clear in the same cycle as the RESP of a hit -> all counters 0.
- rst asserted low in ISSUE -> ds_req=0 immediately, no resp_valid; after release, pointer=0 and a new request on port 3 completes normally.
